// File: rtl/fft_input_framer_pkg.sv
// Shared sizes, state encodings and helpers for the FFT input framer.
// Defaults give a 512-sample frame emitted as 32 beats of 16 lanes.
package fft_input_framer_pkg;

  localparam int DATA  = 13;
  localparam int ARRAY = 16;
  localparam int BEATS = 32;
  localparam int N     = ARRAY * BEATS;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    READING
  } bank_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: BEATS x ARRAY complex words, per-lane write,
// and a registered read port returning a whole beat.
module fft_frame_bank #(
  parameter int DATA  = 13,
  parameter int ARRAY = 16,
  parameter int BEATS = 32,
  parameter int BW    = fft_input_framer_pkg::cw(BEATS)
) (
  input  logic                   clk,
  input  logic [ARRAY-1:0]       wr_en,
  input  logic [BW-1:0]          wr_beat,
  input  logic signed [DATA-1:0] wr_re,
  input  logic signed [DATA-1:0] wr_im,
  input  logic                   rd_en,
  input  logic [BW-1:0]          rd_beat,
  output logic signed [DATA-1:0] rd_re [ARRAY],
  output logic signed [DATA-1:0] rd_im [ARRAY]
);
  import fft_input_framer_pkg::*;

  logic [2*DATA-1:0] mem [ARRAY][BEATS];

  // Store one sample into whichever lane is enabled.
  always_ff @(posedge clk) begin
    for (int l = 0; l < ARRAY; l++) begin
      if (wr_en[l]) begin
        mem[l][wr_beat] <= {wr_re, wr_im};
      end
    end
  end

  // Capture every lane of the requested beat.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int l = 0; l < ARRAY; l++) begin
        rd_re[l] <= mem[l][rd_beat][2*DATA-1:DATA];
        rd_im[l] <= mem[l][rd_beat][DATA-1:0];
      end
    end
  end

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-parallel ping-pong framer feeding an FFT stage.
// Sample n lands in lane n/BEATS, beat n%BEATS.
module fft_input_framer #(
  parameter int DATA  = fft_input_framer_pkg::DATA,
  parameter int ARRAY = fft_input_framer_pkg::ARRAY,
  parameter int BEATS = fft_input_framer_pkg::BEATS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DATA-1:0] s_re,
  input  logic signed [DATA-1:0] s_im,
  input  logic                   s_last,
  input  logic                   out_hold,
  output logic                   valid_out,
  output logic signed [DATA-1:0] dout_re [ARRAY],
  output logic signed [DATA-1:0] dout_im [ARRAY],
  output logic                   frame_start,
  output logic                   err_align
);
  import fft_input_framer_pkg::*;

  localparam int BW = cw(BEATS);
  localparam int LW = cw(ARRAY);

  bank_state_t bank_q [2];
  bank_state_t bank_d [2];
  rd_state_t   rd_q;
  rd_state_t   rd_d;

  logic          wr_bank;
  logic          wr_bank_d;
  logic [BW-1:0] wr_beat;
  logic [LW-1:0] wr_lane;
  logic          accept;
  logic          wr_last;
  logic [ARRAY-1:0] lane_oh;
  logic [ARRAY-1:0] wr_en0;
  logic [ARRAY-1:0] wr_en1;

  logic          rd_bank;
  logic [BW-1:0] rd_cnt;
  logic          rd_act;
  logic          rd_go;
  logic          rd_done;
  logic          rd_en;
  logic [BW-1:0] rd_beat;

  logic q_valid;
  logic q_first;
  logic q_last;
  logic out_last;

  logic signed [DATA-1:0] q0_re [ARRAY];
  logic signed [DATA-1:0] q0_im [ARRAY];
  logic signed [DATA-1:0] q1_re [ARRAY];
  logic signed [DATA-1:0] q1_im [ARRAY];

  assign accept  = s_valid && s_ready;
  assign wr_last = (wr_lane == LW'(ARRAY - 1)) &&
                   (wr_beat == BW'(BEATS - 1));
  assign wr_bank_d = (accept && wr_last) ? ~wr_bank : wr_bank;
  assign wr_en0 = (accept && !wr_bank) ? lane_oh : '0;
  assign wr_en1 = (accept &&  wr_bank) ? lane_oh : '0;

  // One-hot lane select for the sample being written.
  always_comb begin
    lane_oh = '0;
    lane_oh[wr_lane] = 1'b1;
  end

  // Reader decisions: start a burst, issue beat reads, finish.
  always_comb begin
    rd_d    = rd_q;
    rd_go   = 1'b0;
    rd_done = 1'b0;
    rd_en   = 1'b0;
    rd_beat = rd_cnt;
    unique case (rd_q)
      RD_IDLE: begin
        if (bank_q[rd_bank] == FULL && !out_hold) begin
          rd_go   = 1'b1;
          rd_en   = 1'b1;
          rd_beat = '0;
          rd_d    = RD_BURST;
        end
      end
      RD_BURST: begin
        rd_en = rd_act;
        if (valid_out && out_last) begin
          rd_done = 1'b1;
          rd_d    = RD_IDLE;
        end
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  // Bank states: writer and reader never touch the same bank.
  always_comb begin
    bank_d = bank_q;
    if (accept) begin
      bank_d[wr_bank] = wr_last ? FULL : FILLING;
    end
    if (rd_go) begin
      bank_d[rd_bank] = READING;
    end
    if (rd_done) begin
      bank_d[rd_bank] = EMPTY;
    end
  end

  // Write side: counters, bank states, ready and alignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wr_bank   <= 1'b0;
      wr_beat   <= '0;
      wr_lane   <= '0;
      s_ready   <= 1'b0;
      err_align <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      s_ready <= (bank_d[wr_bank_d] == EMPTY) ||
                 (bank_d[wr_bank_d] == FILLING);
      if (accept) begin
        if (s_last != wr_last) begin
          err_align <= 1'b1;
        end
        if (wr_beat == BW'(BEATS - 1)) begin
          wr_beat <= '0;
          wr_lane <= wr_last ? '0 : wr_lane + 1'b1;
        end else begin
          wr_beat <= wr_beat + 1'b1;
        end
        if (wr_last) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // Reader state register and beat-issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= RD_IDLE;
      rd_cnt  <= '0;
      rd_act  <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      rd_q <= rd_d;
      if (rd_go) begin
        rd_cnt <= BW'(1);
        rd_act <= (BEATS > 1);
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == BW'(BEATS - 1)) begin
          rd_act <= 1'b0;
        end
      end
      if (rd_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Output stage: flags follow the bank read by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid     <= 1'b0;
      q_first     <= 1'b0;
      q_last      <= 1'b0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      out_last    <= 1'b0;
      for (int l = 0; l < ARRAY; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
      end
    end else begin
      q_valid     <= rd_en;
      q_first     <= rd_en && (rd_beat == '0);
      q_last      <= rd_en && (rd_beat == BW'(BEATS - 1));
      valid_out   <= q_valid;
      frame_start <= q_valid && q_first;
      out_last    <= q_valid && q_last;
      if (q_valid) begin
        for (int l = 0; l < ARRAY; l++) begin
          dout_re[l] <= rd_bank ? q1_re[l] : q0_re[l];
          dout_im[l] <= rd_bank ? q1_im[l] : q0_im[l];
        end
      end
    end
  end

  fft_frame_bank #(
    .DATA(DATA), .ARRAY(ARRAY), .BEATS(BEATS), .BW(BW)
  ) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en0),
    .wr_beat (wr_beat),
    .wr_re   (s_re),
    .wr_im   (s_im),
    .rd_en   (rd_en && !rd_bank),
    .rd_beat (rd_beat),
    .rd_re   (q0_re),
    .rd_im   (q0_im)
  );

  fft_frame_bank #(
    .DATA(DATA), .ARRAY(ARRAY), .BEATS(BEATS), .BW(BW)
  ) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en1),
    .wr_beat (wr_beat),
    .wr_re   (s_re),
    .wr_im   (s_im),
    .rd_en   (rd_en && rd_bank),
    .rd_beat (rd_beat),
    .rd_re   (q1_re),
    .rd_im   (q1_im)
  );

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench for fft_input_framer against a frame-level
// model: accepted samples are regrouped into expected beats.
module tb_fft_input_framer;
  import fft_input_framer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic out_hold = 1'b0;
  logic signed [DATA-1:0] s_re = '0;
  logic signed [DATA-1:0] s_im = '0;
  logic s_ready, valid_out, frame_start, err_align;
  logic signed [DATA-1:0] dout_re [ARRAY];
  logic signed [DATA-1:0] dout_im [ARRAY];

  always #5 clk = ~clk;

  fft_input_framer #(
    .DATA(DATA), .ARRAY(ARRAY), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .out_hold(out_hold), .valid_out(valid_out),
    .dout_re(dout_re), .dout_im(dout_im),
    .frame_start(frame_start), .err_align(err_align)
  );

  typedef logic [ARRAY-1:0][DATA-1:0] lanes_t;
  typedef struct packed {
    logic   first;
    lanes_t re;
    lanes_t im;
  } beat_t;

  beat_t exp_q [$];
  logic signed [DATA-1:0] fr_re [N];
  logic signed [DATA-1:0] fr_im [N];
  int nfill = 0;
  int run = 0;
  int frames_done = 0;
  int checks = 0;
  int failures = 0;
  int stalls = 0;
  bit armed = 0;
  lanes_t last_re = '0, last_im = '0;
  lanes_t cur_re, cur_im;

  task automatic check(input string name,
                       input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name,
                           input lanes_t act, input lanes_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Compare outputs, then update the model for the coming edge.
  always @(negedge clk) begin
    beat_t e;
    if (armed) begin
      for (int l = 0; l < ARRAY; l++) begin
        cur_re[l] = dout_re[l];
        cur_im[l] = dout_im[l];
      end
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_vec("beat_re", cur_re, e.re);
          check_vec("beat_im", cur_im, e.im);
          check("frame_start", frame_start, e.first);
          if (e.first) begin
            if (run != 0) check("burst_len", run, BEATS);
            run = 1;
          end else begin
            run++;
          end
          if (run == BEATS) frames_done++;
          last_re = e.re;
          last_im = e.im;
        end
      end else begin
        if (run != 0) check("burst_len", run, BEATS);
        run = 0;
        check("idle_start", frame_start, 0);
        check_vec("hold_re", cur_re, last_re);
        check_vec("hold_im", cur_im, last_im);
      end
    end
    if (rst) begin
      armed = 1;
      nfill = 0;
      run = 0;
      exp_q.delete();
      last_re = '0;
      last_im = '0;
    end else if (s_valid && s_ready) begin
      fr_re[nfill] = s_re;
      fr_im[nfill] = s_im;
      if (nfill == N - 1) begin
        for (int b = 0; b < BEATS; b++) begin
          e.first = (b == 0);
          for (int l = 0; l < ARRAY; l++) begin
            e.re[l] = fr_re[l * BEATS + b];
            e.im[l] = fr_im[l * BEATS + b];
          end
          exp_q.push_back(e);
        end
        nfill = 0;
      end else begin
        nfill++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re, input int im, input bit last);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    s_valid = 1'b1;
    s_re = DATA'(re);
    s_im = DATA'(im);
    s_last = last;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      if (!acc) stalls++;
      tick();
      t++;
      if (!acc && t > 3000) begin
        check("send_timeout", t, 3000);
        break;
      end
    end
  endtask

  task automatic send_frames(input int nfr, input bit ramp,
                             input int err_at, input bit gaps);
    int k;
    for (int n = 0; n < nfr * N; n++) begin
      k = n % N;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          s_valid = 1'b0;
          tick();
        end
      end
      if (err_at >= 0 && k == err_at) check("err_before", err_align, 0);
      send(ramp ? k : int'($urandom), ramp ? -k : int'($urandom),
           (k == N - 1) ^ (k == err_at));
      if (err_at >= 0 && k == err_at) check("err_set", err_align, 1);
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (valid_out !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check("wait_valid", valid_out, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || valid_out) && t < 400) begin
      tick();
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic count_valid(input int cyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (valid_out) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int cnt;
    // Reset values.
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_valid", valid_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_err", err_align, 0);
    check("rst_dout", dout_re[0], 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", s_ready, 1);

    // Ramp frame with latency and literal beat values.
    f0 = frames_done;
    send_frames(1, 1'b1, -1, 1'b0);
    s_valid = 1'b0;
    check("lat_t0", valid_out, 0);
    tick();
    check("lat_t1", valid_out, 0);
    tick();
    check("lat_t2", valid_out, 1);
    check("lit_fs0", frame_start, 1);
    check("lit_b0l0", dout_re[0], 0);
    check("lit_b0l3", dout_re[3], 96);
    check("lit_b0l15_im", dout_im[15], -480);
    tick();
    check("lit_fs1", frame_start, 0);
    check("lit_b1l2", dout_re[2], 65);
    check("lit_b1l2_im", dout_im[2], -65);
    drain();
    check("ramp_frames", frames_done, f0 + 1);

    // Three back-to-back frames, no stalls.
    f0 = frames_done;
    stalls = 0;
    send_frames(3, 1'b0, -1, 1'b0);
    s_valid = 1'b0;
    check("b2b_stalls", stalls, 0);
    drain();
    check("b2b_frames", frames_done, f0 + 3);

    // Hold off output while two frames fill both banks.
    f0 = frames_done;
    stalls = 0;
    out_hold = 1'b1;
    send_frames(2, 1'b0, -1, 1'b0);
    s_valid = 1'b0;
    check("hold_stalls", stalls, 0);
    check("hold_ready_low", s_ready, 0);
    count_valid(10, cnt);
    check("hold_no_out", cnt, 0);
    out_hold = 1'b0;
    wait_valid();
    for (int i = 1; i < BEATS; i++) begin
      tick();
      if (i == 5) out_hold = 1'b1;
    end
    check("last_beat_valid", valid_out, 1);
    check("last_beat_ready", s_ready, 0);
    tick();
    check("free_ready", s_ready, 1);
    check("free_valid", valid_out, 0);
    count_valid(8, cnt);
    check("rehold_no_out", cnt, 0);
    out_hold = 1'b0;
    drain();
    check("hold_frames", frames_done, f0 + 2);

    // Misplaced s_last on sample 100.
    f0 = frames_done;
    send_frames(1, 1'b0, 100, 1'b0);
    s_valid = 1'b0;
    drain();
    check("err_sticky", err_align, 1);
    check("err_frames", frames_done, f0 + 1);

    // Reset on beat 10 of a burst, then mid-fill.
    f0 = frames_done;
    send_frames(1, 1'b0, -1, 1'b0);
    s_valid = 1'b0;
    wait_valid();
    repeat (10) tick();
    check("pre_rst_valid", valid_out, 1);
    rst = 1'b1;
    tick();
    check("rst_drop_valid", valid_out, 0);
    check("rst_clear_err", err_align, 0);
    rst = 1'b0;
    count_valid(40, cnt);
    check("rst_no_beats", cnt, 0);
    check("rst_frames", frames_done, f0);
    for (int n = 0; n < 300; n++) send(int'($urandom), int'($urandom), 0);
    rst = 1'b1;
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send_frames(1, 1'b0, -1, 1'b0);
    s_valid = 1'b0;
    drain();
    check("post_rst_frames", frames_done, f0 + 1);
    check("post_rst_err", err_align, 0);

    // Random input gaps.
    f0 = frames_done;
    send_frames(2, 1'b0, -1, 1'b1);
    s_valid = 1'b0;
    drain();
    check("gap_frames", frames_done, f0 + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_input_framer.md
FFT_INPUT_FRAMER -- requirements
Module: fft_input_framer

Interface
REQ-001 The block SHALL have parameter DATA, default 13, meaning the signed width of each real/imag sample.
REQ-002 The block SHALL have parameter ARRAY, default 16, meaning the number of parallel output lanes.
REQ-003 The block SHALL have parameter BEATS, default 32, meaning the output beats per frame (frame N = ARRAY*BEATS = 512 samples).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  serial sample valid.
- s_ready  out  1  framer can accept a sample.
- s_re, s_im  in  DATA signed  serial complex sample.
- s_last  in  1  marks sample N-1 of a frame.
- out_hold  in  1  inhibits the start of a new output burst.
- valid_out  out  1  output beat valid; drives the stage valid_in.
- dout_re, dout_im  out  DATA signed [ARRAY]  parallel beat; drives the stage din_re/din_im.
- frame_start  out  1  high on beat 0 of each burst.
- err_align  out  1  sticky s_last misalignment flag.

Function
REQ-005 The block SHALL accept a sample on every clk edge where s_valid && s_ready, writing it into the current write bank at index n = 0..N-1.
REQ-006 The block SHALL store sample n at lane l = n / BEATS, beat b = n % BEATS (strided mapping).
REQ-007 The block SHALL contain two frame banks (ping-pong), each in one of the states EMPTY, FILLING, FULL or READING.
REQ-008 The write counter SHALL wrap from N-1 to 0; on that wrap the bank SHALL become FULL and writing SHALL move to the other bank.
REQ-009 s_ready SHALL be 1 when the write-target bank is EMPTY or FILLING, and 0 otherwise.
REQ-010 s_ready SHALL be a registered output.
REQ-011 The reader FSM SHALL have two states:
- RD_IDLE: go to RD_BURST when the oldest bank is FULL and out_hold == 0; that bank becomes READING.
- RD_BURST: emit beats 0..BEATS-1 on consecutive cycles, then mark the bank EMPTY and return to RD_IDLE.
REQ-012 valid_out SHALL stay high for exactly BEATS contiguous cycles per frame, with no gaps.
REQ-013 out_hold SHALL be sampled only in RD_IDLE; asserting it mid-burst SHALL NOT shorten or pause the burst.
REQ-014 Latency: if sample N-1 is accepted at edge T and the reader is idle with out_hold low, beat 0 SHALL appear with valid_out = 1 after edge T+2.
REQ-015 dout_re/dout_im SHALL be registered, and SHALL hold their last value when valid_out = 0.
REQ-016 frames SHALL be emitted in arrival order.
REQ-017 When both banks are FULL, s_ready SHALL be 0 until the reader frees a bank; s_ready SHALL return to 1 on the edge after the last beat of the burst.
REQ-018 If a bank becomes FULL on the same edge the reader frees the other bank, both transitions SHALL take effect and no sample SHALL be dropped.
REQ-019 err_align SHALL set when s_last = 1 on an accepted sample with n != N-1, or s_last = 0 with n == N-1; it SHALL clear only on rst.
REQ-020 s_last SHALL NOT alter the counters; framing SHALL be count-based only.
REQ-021 Samples SHALL pass unmodified: no scaling, rounding or width change.

Reset
REQ-022 While rst is high at a clk edge, the block SHALL set both banks EMPTY, the write/read counters to 0 and the reader to RD_IDLE.
REQ-023 While rst is high at a clk edge, the block SHALL set s_ready = 0, valid_out = 0, frame_start = 0, err_align = 0 and dout_re/dout_im = 0.
REQ-024 The block SHALL set s_ready = 1 on the first edge after rst deasserts.
REQ-025 rst asserted mid-fill or mid-burst SHALL discard all partial and buffered frames, and valid_out SHALL drop on that same edge.
REQ-026 Bank storage contents SHALL NOT need to be reset.

Structure
REQ-027 A shared package SHALL hold DATA, ARRAY, BEATS, N, a bank-state enum (EMPTY/FILLING/FULL/READING) and a reader-state enum (RD_IDLE/RD_BURST).
REQ-028 Each bank SHALL be one sub-module, fft_frame_bank: BEATS x ARRAY x 2*DATA storage, with a per-lane write enable and a one-beat registered read port. The framer SHALL instantiate it twice.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Ramp frame (s_re = n, s_im = -n, s_valid held high, out_hold = 0) -> 32 contiguous valid_out beats; beat b lane l has re = 32*l + b; beat 0 appears after edge T+2 per REQ-014; frame_start high only on beat 0.
- Three back-to-back frames, s_valid always high -> s_ready stays 1 throughout; bursts appear in order, each exactly 32 beats.
- out_hold = 1 while 1024 samples are sent -> s_ready falls to 0 after sample 1023; releasing hold gives frame 0 then frame 1, and s_ready = 1 the edge after frame 0's last beat.
- s_last pulsed on sample 100 -> err_align = 1 from the next edge and stays set; the frame is still emitted at sample 511.
- rst pulsed on beat 10 of a burst -> valid_out = 0 the same edge; no further beats; the next full frame emits normally.
- Random s_valid gaps (50% duty) -> output data matches the reference model bit-exactly; valid_out gap-free within each burst.
